// File: rtl/moore_sym_pkg.sv
// Shared definitions for the 2-bit symbol protocol: symbol values, the
// encoder state encoding and the default inter-command gap length.
package moore_sym_pkg;

  localparam logic [1:0] SYM_IDLE = 2'b00;
  localparam logic [1:0] SYM_CLR  = 2'b01;
  localparam logic [1:0] SYM_TGL  = 2'b10;
  localparam logic [1:0] SYM_SET  = 2'b11;

  // Idle symbols following every command symbol; the decoder's frame length.
  localparam int GAP_LEN_DEFAULT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYM  = 2'd1,
    ST_GAP  = 2'd2
  } enc_state_t;

  // Decoder output after a completed frame carrying symbol s.
  function automatic logic apply_sym(input logic y, input logic [1:0] s);
    logic y_n;
    y_n = y;
    case (s)
      SYM_CLR: y_n = 1'b0;
      SYM_SET: y_n = 1'b1;
      SYM_TGL: y_n = ~y;
      default: y_n = y;
    endcase
    return y_n;
  endfunction

endpackage

// File: rtl/moore_cmd_fifo.sv
// Synchronous command queue, 2-bit entries, first-word-fall-through read.
// A push while full is accepted only when a pop happens in the same cycle,
// in which case the new entry takes the slot being vacated.
module moore_cmd_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [1:0]                  din,
  input  logic                        pop,
  output logic [1:0]                  dout,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at 2**AW.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/moore_sym_encoder.sv
// Frames queued clear/toggle/set commands into symbol streams for the Moore
// sequence decoder: one command symbol followed by GAP_LEN idle symbols.
// Optional predicted-decoder-output register: define MOORE_ENC_SHADOW_EN.
//
// Handshake: a command is taken on a rising edge where cmd_valid && cmd_ready
// && cmd != 00. cmd_ready depends only on registered occupancy. cmd = 00 with
// cmd_valid && cmd_ready is dropped and flagged on err_illegal; cmd_valid
// while cmd_ready is low is ignored.
//
// aout, frame_done and y_shadow are registered and trail the FSM by one
// cycle: aout shows the command the cycle after the FSM sat in SYM.
module moore_sym_encoder
  import moore_sym_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_LEN    = GAP_LEN_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  output logic       cmd_ready,
  output logic [1:0] aout,
  output logic       busy,
  output logic       frame_done,
`ifdef MOORE_ENC_SHADOW_EN
  output logic       y_shadow,
`endif
  output logic       err_illegal
);

  localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // FSM state is kept as a named signal so checkers can bind to it.
  enc_state_t    state;
  logic [GW-1:0] gap_cnt;
  logic [1:0]    cur_cmd;
  logic          fifo_full;
  logic          fifo_empty;
  logic [1:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          push;
  logic          pop;
  logic          last_gap;

  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready && (cmd != SYM_IDLE);
  assign last_gap  = (state == ST_GAP) && (gap_cnt == '0);
  assign pop       = ((state == ST_IDLE) || last_gap) && !fifo_empty;
  assign busy      = (state != ST_IDLE) || (fifo_count != '0);

  moore_cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (cmd),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Flag an illegal 00 command offered while the queue could accept.
  always_ff @(posedge clk) begin
    if (reset) err_illegal <= 1'b0;
    else       err_illegal <= cmd_valid && cmd_ready && (cmd == SYM_IDLE);
  end

`ifdef MOORE_ENC_SHADOW_EN
  logic [1:0] done_cmd;
`endif

  // Framing FSM: pop a command, emit it once, then count out the gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      gap_cnt    <= '0;
      cur_cmd    <= SYM_IDLE;
      aout       <= SYM_IDLE;
      frame_done <= 1'b0;
`ifdef MOORE_ENC_SHADOW_EN
      done_cmd   <= SYM_IDLE;
`endif
    end else begin
      aout       <= SYM_IDLE;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            cur_cmd <= fifo_dout;
            state   <= ST_SYM;
          end
        end
        ST_SYM: begin
          aout    <= cur_cmd;
          gap_cnt <= GW'(GAP_LEN - 1);
          state   <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            frame_done <= 1'b1;
`ifdef MOORE_ENC_SHADOW_EN
            done_cmd   <= cur_cmd;
`endif
            if (pop) begin
              cur_cmd <= fifo_dout;
              state   <= ST_SYM;
            end else begin
              state   <= ST_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MOORE_ENC_SHADOW_EN
  // Predicted decoder output, updated the cycle after each frame completes.
  always_ff @(posedge clk) begin
    if (reset)           y_shadow <= 1'b0;
    else if (frame_done) y_shadow <= apply_sym(y_shadow, done_cmd);
  end
`endif

endmodule

// File: tb/tb_moore_sym_encoder.sv
// Self-checking bench for moore_sym_encoder: a directed vector table, hand
// sequences for framing corner cases, and randomized traffic against a
// schedule-level reference model plus a behavioural decoder on aout.
module tb_moore_sym_encoder;

  localparam int DEPTH = 4;
  localparam int GAP   = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_ready;
  logic [1:0] aout;
  logic       busy;
  logic       frame_done;
  logic       err_illegal;
`ifdef MOORE_ENC_SHADOW_EN
  logic       y_shadow;
`endif

  moore_sym_encoder #(.FIFO_DEPTH(DEPTH), .GAP_LEN(GAP)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd         (cmd),
    .cmd_ready   (cmd_ready),
    .aout        (aout),
    .busy        (busy),
    .frame_done  (frame_done),
`ifdef MOORE_ENC_SHADOW_EN
    .y_shadow    (y_shadow),
`endif
    .err_illegal (err_illegal)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic ref_apply(input logic y, input logic [1:0] s);
    if (s == 2'b01) return 1'b0;
    if (s == 2'b11) return 1'b1;
    if (s == 2'b10) return !y;
    return y;
  endfunction

  // ---------------- reference model (pop schedule) ----------------
  // A command is popped on an edge when the queue held something before the
  // edge and at least GAP+1 edges have passed since the previous pop. Its
  // symbol appears after pop+1; its frame completes after pop+GAP+1.
  logic [1:0] m_q[$];
  int         m_edge = 0;
  bit         m_has_pop = 0;
  int         m_pop_edge = 0;
  logic [1:0] m_pop_cmd = 2'b00;
  logic       m_y = 1'b0;
  bit         m_pend = 0;
  logic [1:0] m_pend_cmd = 2'b00;
  int         m_accepted = 0;
  logic [1:0] e_aout;
  logic       e_fd, e_err, e_ready, e_busy, e_y;

  task automatic model_edge(input logic v, input logic [1:0] c, input logic r);
    int  occ;
    bit  rdy;
    bit  do_pop;
    m_edge++;
    if (r) begin
      m_q.delete();
      m_has_pop = 0;
      m_y = 1'b0; m_pend = 0;
      e_aout = 2'b00; e_fd = 0; e_err = 0; e_ready = 1; e_busy = 0; e_y = 0;
      return;
    end
    if (m_pend) begin
      m_y = ref_apply(m_y, m_pend_cmd);
      m_pend = 0;
    end
    occ    = m_q.size();
    rdy    = (occ < DEPTH);
    e_aout = (m_has_pop && m_edge == m_pop_edge + 1) ? m_pop_cmd : 2'b00;
    e_fd   = m_has_pop && (m_edge == m_pop_edge + GAP + 1);
    if (e_fd) begin
      m_pend = 1; m_pend_cmd = m_pop_cmd;
    end
    e_err  = v && rdy && (c == 2'b00);
    do_pop = (occ > 0) && (!m_has_pop || m_edge >= m_pop_edge + GAP + 1);
    if (do_pop) begin
      m_pop_cmd  = m_q.pop_front();
      m_pop_edge = m_edge;
      m_has_pop  = 1;
    end
    if (v && rdy && c != 2'b00) begin
      m_q.push_back(c);
      m_accepted++;
    end
    e_ready = (m_q.size() < DEPTH);
    e_busy  = (m_q.size() > 0) || (m_has_pop && m_edge < m_pop_edge + GAP + 1);
    e_y     = m_y;
  endtask

  // ---------------- behavioural decoder on the aout stream ----------------
  logic       dec_y = 1'b0;
  logic [1:0] dec_sym = 2'b00;
  int         dec_zeros = 0;
  bit         dec_apply = 0;
  bit         last_fd = 0;

  // ---------------- capture for hand-written sequences ----------------
  bit         cap_en = 0;
  bit         cap_started = 0;
  logic [1:0] cap_q[$];
  logic       ycap_q[$];
  int         sym_cnt = 0;
  bit         saw_not_ready = 0;

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle(input logic v, input logic [1:0] c, input logic r);
    cmd_valid = v; cmd = c; reset = r;
    @(posedge clk);
    model_edge(v, c, r);
    #1;
    chk("aout", 32'(aout), 32'(e_aout));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("err_illegal", 32'(err_illegal), 32'(e_err));
    chk("cmd_ready", 32'(cmd_ready), 32'(e_ready));
    chk("busy", 32'(busy), 32'(e_busy));
`ifdef MOORE_ENC_SHADOW_EN
    chk("y_shadow", 32'(y_shadow), 32'(e_y));
`endif
    if (r) begin
      dec_y = 0; dec_sym = 0; dec_zeros = 0; dec_apply = 0; last_fd = 0;
    end else begin
      if (dec_apply) begin
        dec_y = ref_apply(dec_y, dec_sym);
        dec_sym = 2'b00;
        dec_apply = 0;
      end
`ifdef MOORE_ENC_SHADOW_EN
      if (last_fd) chk("loopback_y", 32'(y_shadow), 32'(dec_y));
      if (last_fd && cap_en) ycap_q.push_back(y_shadow);
`endif
      if (aout != 2'b00) begin
        dec_sym = aout; dec_zeros = 0;
      end else if (dec_sym != 2'b00) begin
        dec_zeros++;
        if (dec_zeros == GAP) dec_apply = 1;
      end
      last_fd = e_fd;
    end
    if (cap_en) begin
      if (aout != 2'b00) begin
        cap_started = 1;
        sym_cnt++;
      end
      if (cap_started) cap_q.push_back(aout);
      if (!cmd_ready) saw_not_ready = 1;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       v;
    logic [1:0] c;
    logic [1:0] aout;
    logic       fd;
    logic       ready;
    logic       busy;
    logic       y;
  } vec_t;

  vec_t tbl[7];

  logic [1:0] exp_q[$];
  logic       exp_y[$];

  initial begin
    int acc0;
    cmd_valid = 0; cmd = 2'b00; reset = 1;

    // reset over edges 1 and 2; outputs must be at their reset values
    cycle(0, 2'b00, 1);
    cycle(0, 2'b00, 1);
    chk("reset_aout", 32'(aout), 32'd0);
    chk("reset_ready", 32'(cmd_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);

    // single command 11 pushed at edge 3: symbol after edge 5, done after 7
    tbl[0] = '{1'b1, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 2'b00, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].v, tbl[i].c, 1'b0);
      chk("tbl_aout", 32'(aout), 32'(tbl[i].aout));
      chk("tbl_frame_done", 32'(frame_done), 32'(tbl[i].fd));
      chk("tbl_ready", 32'(cmd_ready), 32'(tbl[i].ready));
      chk("tbl_busy", 32'(busy), 32'(tbl[i].busy));
`ifdef MOORE_ENC_SHADOW_EN
      chk("tbl_y_shadow", 32'(y_shadow), 32'(tbl[i].y));
`endif
    end

    // back-to-back frames with no extra idle symbols
    exp_q = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00,
              2'b10, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00};
    exp_y = '{1'b0, 1'b1, 1'b0, 1'b1};
    cap_q.delete(); ycap_q.delete(); cap_started = 0; cap_en = 1;
    cycle(1, 2'b01, 0);
    cycle(1, 2'b10, 0);
    cycle(1, 2'b10, 0);
    cycle(1, 2'b11, 0);
    for (int i = 0; i < 16; i++) cycle(0, 2'b00, 0);
    cap_en = 0;
    chk("b2b_len", 32'(cap_q.size() >= 12), 32'd1);
    for (int i = 0; i < 12 && i < cap_q.size(); i++) chk("b2b_aout", 32'(cap_q[i]), 32'(exp_q[i]));
    chk("b2b_busy_end", 32'(busy), 32'd0);
`ifdef MOORE_ENC_SHADOW_EN
    chk("b2b_ycount", 32'(ycap_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < ycap_q.size(); i++) chk("b2b_y", 32'(ycap_q[i]), 32'(exp_y[i]));
`endif

    // backpressure: offer 11 for 8 cycles into an idle encoder
    acc0 = m_accepted; sym_cnt = 0; saw_not_ready = 0; cap_started = 0; cap_en = 1;
    for (int i = 0; i < 8; i++) cycle(1, 2'b11, 0);
    for (int i = 0; i < 30; i++) cycle(0, 2'b00, 0);
    cap_en = 0;
    chk("bp_ready_dropped", 32'(saw_not_ready), 32'd1);
    chk("bp_no_loss", 32'(sym_cnt), 32'(m_accepted - acc0));
    chk("bp_symbols", 32'(sym_cnt), 32'd6);

    // illegal command: one-cycle pulse, nothing queued, line stays idle
    cycle(1, 2'b00, 0);
    chk("illegal_pulse", 32'(err_illegal), 32'd1);
    cycle(0, 2'b00, 0);
    chk("illegal_pulse_end", 32'(err_illegal), 32'd0);
    chk("illegal_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 2'b00, 0);
      chk("illegal_aout", 32'(aout), 32'd0);
    end

    // reset during the first gap cycle of a 10 frame with two queued
    cycle(1, 2'b10, 0);
    cycle(1, 2'b11, 0);
    cycle(1, 2'b11, 0);
    chk("rst_mid_sym", 32'(aout), 32'd2);
    cycle(0, 2'b00, 1);
    chk("rst_mid_aout", 32'(aout), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_ready", 32'(cmd_ready), 32'd1);
`ifdef MOORE_ENC_SHADOW_EN
    chk("rst_mid_y", 32'(y_shadow), 32'd0);
`endif
    for (int i = 0; i < 8; i++) begin
      cycle(0, 2'b00, 0);
      chk("rst_mid_quiet", 32'(aout), 32'd0);
    end

    // randomized loopback traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      logic       v;
      logic [1:0] c;
      logic       r;
      v = ($urandom_range(0, 3) != 0);
      c = 2'($urandom_range(0, 3));
      r = ($urandom_range(0, 149) == 0);
      cycle(v, c, r);
    end
    for (int i = 0; i < 20; i++) cycle(0, 2'b00, 0);
    chk("drain_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
